// File: rtl/bit_channel_arbiter_pkg.sv
// Shared definitions for the bit_channel_arbiter block.
//   state_e            FSM state encoding (idle, granting a burst, one-cycle separator)
//   IDLE_LEVEL_DEFAULT level driven on the serial line when nothing is transferred
//   onehot_bit         one bit of a one-hot vector selected by an index
package bit_channel_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StGap   = 2'd2
    } state_e;

    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

    // Bit 'pos' of onehot(idx); the caller builds a vector of whatever width it needs.
    function automatic logic onehot_bit(input int unsigned idx, input int unsigned pos);
        return idx == pos;
    endfunction

endpackage

// File: rtl/bit_channel_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     per-requester request levels
//   pointer index of the previous winner; the search starts just after it
//   any     at least one request is pending
//   pick    index of the first requester found, searching cyclically from pointer+1
module rr_pick #(
    parameter int unsigned  N_REQ = 4,
    localparam int unsigned OW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OW-1:0]    pointer,
    output logic             any,
    output logic [OW-1:0]    pick
);

    int unsigned   idx;
    logic [OW-1:0] idx_w;

    always_comb begin
        any   = 1'b0;
        pick  = '0;
        idx   = 0;
        idx_w = '0;
        // Offset 1 first, offset N_REQ last, so the previous winner has lowest priority.
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx   = (32'(pointer) + i) % N_REQ;
            idx_w = OW'(idx);
            if (!any && req[idx_w]) begin
                any  = 1'b1;
                pick = idx_w;
            end
        end
    end

endmodule

// File: rtl/bit_channel_arbiter.sv
// Round-robin arbiter sharing the single-bit serial input of the downstream datapath.
//   clk, rst_n  clock, asynchronous active-low reset
//   req         per-requester request (level)
//   req_bit     per-requester serial data bit
//   gnt         one-hot grant (registered)
//   a_out       serial bit to the datapath (registered, lags gnt by one cycle)
//   a_valid     a_out carries a transferred bit
//   busy        arbiter is in the granting state
//   owner       index of the current or most recent grantee
//   burst_cnt   bits transferred in the current burst
module bit_channel_arbiter
    import bit_channel_arbiter_pkg::*;
#(
    parameter int unsigned  N_REQ      = 4,
    parameter int unsigned  BURST_LEN  = 8,
    parameter logic         IDLE_LEVEL = IDLE_LEVEL_DEFAULT,
    localparam int unsigned OW         = $clog2(N_REQ),
    localparam int unsigned CW         = $clog2(BURST_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_bit,
    output logic [N_REQ-1:0] gnt,
    output logic             a_out,
    output logic             a_valid,
    output logic             busy,
    output logic [OW-1:0]    owner,
    output logic [CW-1:0]    burst_cnt
);

    state_e           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic             a_out_q;
    logic             a_valid_q;
    logic             busy_q;
    logic [OW-1:0]    owner_q;
    logic [OW-1:0]    ptr_q;
    logic [CW-1:0]    burst_cnt_q;

    logic             pick_any;
    logic [OW-1:0]    pick;
    logic [N_REQ-1:0] pick_oh;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req     (req),
        .pointer (ptr_q),
        .any     (pick_any),
        .pick    (pick)
    );

    always_comb begin
        pick_oh = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            pick_oh[i] = onehot_bit(32'(pick), i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            a_out_q     <= IDLE_LEVEL;
            a_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= OW'(N_REQ - 1);  // first search starts at requester 0
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                // The gap cycle arbitrates exactly like idle; it only exists to force
                // one cycle of gnt low (and the idle level afterwards) between bursts.
                StIdle, StGap: begin
                    a_out_q   <= IDLE_LEVEL;
                    a_valid_q <= 1'b0;
                    if (pick_any) begin
                        gnt_q       <= pick_oh;
                        owner_q     <= pick;
                        ptr_q       <= pick;
                        burst_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StGrant;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StGrant: begin
                    if (req[owner_q]) begin
                        a_out_q     <= req_bit[owner_q];
                        a_valid_q   <= 1'b1;
                        burst_cnt_q <= burst_cnt_q + CW'(1);
                        if (burst_cnt_q == CW'(BURST_LEN - 1)) begin
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= StGap;
                        end
                    end else begin
                        // Early release: nothing transferred this cycle.
                        a_out_q   <= IDLE_LEVEL;
                        a_valid_q <= 1'b0;
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= StGap;
                    end
                end
                default: begin
                    gnt_q     <= '0;
                    a_out_q   <= IDLE_LEVEL;
                    a_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign a_out     = a_out_q;
    assign a_valid   = a_valid_q;
    assign busy      = busy_q;
    assign owner     = owner_q;
    assign burst_cnt = burst_cnt_q;

endmodule
